// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the JTDSP16 address arithmetic units: post-modify
// encodings, register select codes and the access FSM state encoding.
package jtdsp16_pkg;

    localparam logic [1:0] PM_NONE = 2'b00;
    localparam logic [1:0] PM_INC  = 2'b01;
    localparam logic [1:0] PM_DEC  = 2'b10;
    localparam logic [1:0] PM_J    = 2'b11;

    localparam logic [2:0] RS_R0 = 3'd0;
    localparam logic [2:0] RS_R1 = 3'd1;
    localparam logic [2:0] RS_R2 = 3'd2;
    localparam logic [2:0] RS_R3 = 3'd3;
    localparam logic [2:0] RS_J  = 3'd4;
    localparam logic [2:0] RS_K  = 3'd5;
    localparam logic [2:0] RS_RB = 3'd6;
    localparam logic [2:0] RS_RE = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ZWR  = 1'b1
    } yaau_state_t;

endpackage

// File: rtl/jtdsp16_yaau_mod.sv
// Combinational next-pointer calculation shared by the X and Y address units.
// Post-increment wraps from re back to rb when a circular buffer is active.
module jtdsp16_yaau_mod
    import jtdsp16_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] ptr,
    input  logic [1:0]    post_mod,
    input  logic          use_k,
    input  logic [DW-1:0] j,
    input  logic [DW-1:0] k,
    input  logic [DW-1:0] rb,
    input  logic [DW-1:0] re,
    output logic [DW-1:0] nxt
);

    localparam logic [DW-1:0] ONE  = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] ZERO = {DW{1'b0}};

    logic [DW-1:0] step_s;
    logic          circ_hit_s;

    // Select the stride and compute the modified pointer
    always_comb begin
        step_s     = j;
        circ_hit_s = 1'b0;
        nxt        = ptr;
        if (use_k) begin
            step_s = k;
        end else begin
            step_s = j;
        end
        // re=0 disables the circular buffer
        if ((re != ZERO) && (ptr == re)) begin
            circ_hit_s = 1'b1;
        end else begin
            circ_hit_s = 1'b0;
        end
        case (post_mod)
            PM_NONE: nxt = ptr;
            PM_INC: begin
                if (circ_hit_s) begin
                    nxt = rb;
                end else begin
                    nxt = ptr + ONE;
                end
            end
            PM_DEC:  nxt = ptr - ONE;
            PM_J:    nxt = ptr + step_s;
            default: nxt = ptr;
        endcase
    end

endmodule

// File: rtl/jtdsp16_yaau.sv
// Y-space address arithmetic unit: turns read/write/compound requests into
// registered RAM cycles and post-modifies the selected pointer register.
module jtdsp16_yaau
    import jtdsp16_pkg::*;
#(
    parameter int AW = 11,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic [1:0]    ptr_sel,
    input  logic [1:0]    post_mod,
    input  logic          acc_rd,
    input  logic          acc_wr,
    input  logic          acc_z,
    input  logic [DW-1:0] wr_data,
    input  logic          reg_load,
    input  logic [2:0]    reg_sel,
    input  logic [DW-1:0] reg_din,
    output logic [DW-1:0] reg_dout,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    output logic          busy
);

    logic [DW-1:0] ptr_r [0:3];
    logic [DW-1:0] j_r;
    logic [DW-1:0] k_r;
    logic [DW-1:0] rb_r;
    logic [DW-1:0] re_r;

    yaau_state_t   state_r;
    yaau_state_t   state_nxt_s;
    logic [AW-1:0] ram_addr_r;
    logic [DW-1:0] ram_din_r;
    logic          ram_we_r;
    logic          busy_r;
    logic [1:0]    zsel_r;
    logic [1:0]    zmod_r;
    logic [DW-1:0] zdata_r;

    logic [AW-1:0] addr_nxt_s;
    logic [DW-1:0] din_nxt_s;
    logic          we_nxt_s;
    logic          busy_nxt_s;
    logic [1:0]    zsel_nxt_s;
    logic [1:0]    zmod_nxt_s;
    logic [DW-1:0] zdata_nxt_s;

    logic          mod_en_s;
    logic [1:0]    mod_sel_s;
    logic [1:0]    mod_pm_s;
    logic          mod_use_k_s;
    logic [DW-1:0] mod_ptr_s;
    logic [DW-1:0] mod_nxt_s;
    logic [DW-1:0] acc_ptr_s;

    assign acc_ptr_s = ptr_r[ptr_sel];
    assign mod_ptr_s = ptr_r[mod_sel_s];

    jtdsp16_yaau_mod #(
        .DW (DW)
    ) u_mod (
        .ptr      (mod_ptr_s),
        .post_mod (mod_pm_s),
        .use_k    (mod_use_k_s),
        .j        (j_r),
        .k        (k_r),
        .rb       (rb_r),
        .re       (re_r),
        .nxt      (mod_nxt_s)
    );

    // Access FSM: next RAM cycle, compound latches and pointer update request
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = ram_addr_r;
        din_nxt_s   = ram_din_r;
        we_nxt_s    = 1'b0;
        busy_nxt_s  = 1'b0;
        zsel_nxt_s  = zsel_r;
        zmod_nxt_s  = zmod_r;
        zdata_nxt_s = zdata_r;
        mod_en_s    = 1'b0;
        mod_sel_s   = ptr_sel;
        mod_pm_s    = post_mod;
        mod_use_k_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (acc_z) begin
                    addr_nxt_s  = acc_ptr_s[AW-1:0];
                    zsel_nxt_s  = ptr_sel;
                    zmod_nxt_s  = post_mod;
                    zdata_nxt_s = wr_data;
                    busy_nxt_s  = 1'b1;
                    state_nxt_s = ST_ZWR;
                end else if (acc_wr) begin
                    addr_nxt_s = acc_ptr_s[AW-1:0];
                    din_nxt_s  = wr_data;
                    we_nxt_s   = 1'b1;
                    mod_en_s   = 1'b1;
                end else if (acc_rd) begin
                    addr_nxt_s = acc_ptr_s[AW-1:0];
                    mod_en_s   = 1'b1;
                end else begin
                    we_nxt_s = 1'b0;
                end
            end
            ST_ZWR: begin
                // Write-back half of a compound access; the +j code means +k here
                din_nxt_s   = zdata_r;
                we_nxt_s    = 1'b1;
                mod_en_s    = 1'b1;
                mod_sel_s   = zsel_r;
                mod_pm_s    = zmod_r;
                mod_use_k_s = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Registered RAM interface and FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ram_addr_r <= {AW{1'b0}};
            ram_din_r  <= {DW{1'b0}};
            ram_we_r   <= 1'b0;
            busy_r     <= 1'b0;
            zsel_r     <= 2'b00;
            zmod_r     <= 2'b00;
            zdata_r    <= {DW{1'b0}};
        end else if (cen) begin
            state_r    <= state_nxt_s;
            ram_addr_r <= addr_nxt_s;
            ram_din_r  <= din_nxt_s;
            ram_we_r   <= we_nxt_s;
            busy_r     <= busy_nxt_s;
            zsel_r     <= zsel_nxt_s;
            zmod_r     <= zmod_nxt_s;
            zdata_r    <= zdata_nxt_s;
        end
    end

    // Pointer file: an explicit load beats the post-modification
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                ptr_r[i] <= {DW{1'b0}};
            end
        end else if (cen) begin
            for (int i = 0; i < 4; i++) begin
                if (reg_load && (reg_sel == 3'(i))) begin
                    ptr_r[i] <= reg_din;
                end else if (mod_en_s && (mod_sel_s == 2'(i))) begin
                    ptr_r[i] <= mod_nxt_s;
                end
            end
        end
    end

    // Increment and circular-bound registers, written only by reg_load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j_r  <= {DW{1'b0}};
            k_r  <= {DW{1'b0}};
            rb_r <= {DW{1'b0}};
            re_r <= {DW{1'b0}};
        end else if (cen && reg_load) begin
            case (reg_sel)
                RS_J:    j_r  <= reg_din;
                RS_K:    k_r  <= reg_din;
                RS_RB:   rb_r <= reg_din;
                RS_RE:   re_r <= reg_din;
                default: j_r  <= j_r;
            endcase
        end
    end

    // Combinational register readback
    always_comb begin
        reg_dout = {DW{1'b0}};
        case (reg_sel)
            RS_R0:   reg_dout = ptr_r[0];
            RS_R1:   reg_dout = ptr_r[1];
            RS_R2:   reg_dout = ptr_r[2];
            RS_R3:   reg_dout = ptr_r[3];
            RS_J:    reg_dout = j_r;
            RS_K:    reg_dout = k_r;
            RS_RB:   reg_dout = rb_r;
            RS_RE:   reg_dout = re_r;
            default: reg_dout = {DW{1'b0}};
        endcase
    end

    assign ram_addr = ram_addr_r;
    assign ram_din  = ram_din_r;
    assign ram_we   = ram_we_r;
    assign busy     = busy_r;

endmodule
